div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative radix-2 integer divider for 32-bit DIV/DIVU. It is the inverse-operation companion of the pipelined multiplier.
- Sits in the same execution cluster and uses the same tag/complete result interface (ROB pointer, HILO PRF pointer, 64-bit y).
- It is multi-cycle and non-pipelined, so it exposes a ready signal to the scheduler. The scheduler issues only when ready is high.
- Result packing: y = {remainder, quotient}, i.e. HI = remainder, LO = quotient.

Parameters:
- W, 32, operand width (the only supported value is 32; the parameter exists for readability).
- ROB_W, 6, ROB pointer width.
- HILO_W, 2, HILO PRF pointer width.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- go  input  1  issue strobe; accepted only when ready=1
- is_signed  input  1  1=DIV (two's complement), 0=DIVU
- src_A  input  W  dividend
- src_B  input  W  divisor
- rob_ptr_in  input  ROB_W  ROB tag of the issuing op
- hilo_prf_ptr_in  input  HILO_W  destination HILO physical register
- ready  output  1  unit idle, can accept go
- y  output  2W  {remainder, quotient}; valid only while complete=1
- complete  output  1  one-cycle result strobe
- rob_ptr_out  output  ROB_W  tag accompanying complete
- hilo_prf_ptr_val_out  output  1  equals complete
- hilo_prf_ptr_out  output  HILO_W  destination accompanying complete

Behaviour:
- Reset values: state=IDLE, ready=1, complete=0, hilo_prf_ptr_val_out=0, y=0, rob_ptr_out=0, hilo_prf_ptr_out=0, iteration counter=0.
- Reset mid-operation: abort the op, return to IDLE on the next edge, and never assert complete for the aborted op.
- FSM states: IDLE, DIVIDE, FIX, DONE.
- IDLE, go=1 (cycle T):
  - Latch tags and is_signed.
  - Latch the magnitudes |A| and |B| (raw values when is_signed=0).
  - Latch the sign flags: qneg = sA^sB, rneg = sA (both 0 when unsigned).
  - Clear the 33-bit partial remainder.
  - Set counter = 31 and go to DIVIDE.
- DIVIDE (cycles T+1..T+32): restoring step once per cycle.
  - rem' = {rem[31:0], dividend_msb}; shift the dividend left.
  - If rem' >= divisor: rem = rem' - divisor and shift in quotient bit 1; else rem = rem' and shift in 0.
  - Leave DIVIDE after the counter-0 step.
- FIX (T+33):
  - Negate the quotient if qneg; negate the remainder if rneg.
  - Apply the special cases (below), which override the computed result.
  - Load the output registers.
- DONE (T+34): complete=1, hilo_prf_ptr_val_out=1, y/tags valid. Next state is IDLE.
- ready:
  - High in IDLE only.
  - Low from T+1 until DONE inclusive.
  - Back-to-back issue is possible at the cycle after DONE.
- go while ready=0 is ignored; the scheduler must not do this, and the bench checks that it has no effect.
- complete is exactly one cycle per accepted go. Outputs hold their values after complete, but are not valid.
- Divide-by-zero (B=0): quotient = 32'hFFFF_FFFF, remainder = A (unsigned and signed alike).
- Signed overflow (A=32'h8000_0000, B=32'hFFFF_FFFF, is_signed=1): quotient = 32'h8000_0000, remainder = 0.
- Magnitude of 32'h8000_0000 is 32'h8000_0000, treated as unsigned internally.
- Remainder sign follows the dividend; quotient truncates toward zero.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: if B=0, or |A| < |B|, or A=0, skip DIVIDE.
  - IDLE goes straight to FIX at T+1, so complete is at T+2.
  - For the |A| < |B| and A=0 cases: quotient = 0, remainder = A (sign preserved).
  - Divide-by-zero gives the result defined above.
- When undefined: every op takes the fixed 34-cycle latency (complete at T+34). Results are identical either way; only latency differs.

Test Plan:
- DIVU A=100, B=7, rob=5, hilo=2 at T -> complete only at T+34; y={32'd2, 32'd14}; rob_ptr_out=5; hilo_prf_ptr_out=2; ready low T+1..T+34.
- DIV A=-100 (32'hFFFF_FF9C), B=7 -> quotient 32'hFFFF_FFF2 (-14), remainder 32'hFFFF_FFFE (-2).
- DIV A=32'h8000_0000, B=-1 -> y={32'd0, 32'h8000_0000}. DIVU A=32'h8000_0000, B=32'hFFFF_FFFF -> y={32'h8000_0000, 32'd0}.
- B=0, A=123, signed and unsigned -> y={32'd123, 32'hFFFF_FFFF}; with DIV_EARLY_OUT_EN, complete at T+2, otherwise at T+34.
- Pulse go again at T+5 while busy with A=50, B=5 -> ignored; exactly one complete, carrying the first op's tags. A new go at T+35 -> accepted.
- Reset asserted at T+10 mid-divide -> ready=1 at T+11, no complete ever for that op; the next op computes correctly.

Source files
------------

// File: rtl/div_iter_if.sv
// rtl/div_iter_if.sv - issue/result bundle between the scheduler and the iterative divider
//
// Signals:
//   go, is_signed, src_A, src_B,          scheduler -> divider: issue strobe and operands
//   rob_ptr_in, hilo_prf_ptr_in           scheduler -> divider: tags of the issuing op
//   ready                                 divider -> scheduler: unit idle, may issue
//   y, complete, rob_ptr_out,             divider -> scheduler: {remainder, quotient},
//   hilo_prf_ptr_val_out, hilo_prf_ptr_out  one-cycle result strobe and returned tags
// Modports: master (scheduler side), slave (divider side).

interface div_iter_if #(
  parameter int W      = 32,
  parameter int ROB_W  = 6,
  parameter int HILO_W = 2
);
  logic              go;
  logic              is_signed;
  logic [W-1:0]      src_A;
  logic [W-1:0]      src_B;
  logic [ROB_W-1:0]  rob_ptr_in;
  logic [HILO_W-1:0] hilo_prf_ptr_in;
  logic              ready;
  logic [2*W-1:0]    y;
  logic              complete;
  logic [ROB_W-1:0]  rob_ptr_out;
  logic              hilo_prf_ptr_val_out;
  logic [HILO_W-1:0] hilo_prf_ptr_out;

  modport master (
    output go, is_signed, src_A, src_B, rob_ptr_in, hilo_prf_ptr_in,
    input  ready, y, complete, rob_ptr_out, hilo_prf_ptr_val_out, hilo_prf_ptr_out
  );

  modport slave (
    input  go, is_signed, src_A, src_B, rob_ptr_in, hilo_prf_ptr_in,
    output ready, y, complete, rob_ptr_out, hilo_prf_ptr_val_out, hilo_prf_ptr_out
  );
endinterface

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider for 32-bit DIV/DIVU
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   dif    div_iter_if.slave: go/is_signed/src_A/src_B/rob_ptr_in/hilo_prf_ptr_in in,
//          ready/y/complete/rob_ptr_out/hilo_prf_ptr_val_out/hilo_prf_ptr_out out
// Result packing: y = {remainder, quotient}. Fixed latency: complete at T+34 for go at T.
// Optional: define DIV_EARLY_OUT_EN to skip the divide loop when B=0, A=0 or |A|<|B|
// (complete at T+2); results are identical either way.

module div_iter #(
  parameter int W      = 32,
  parameter int ROB_W  = 6,
  parameter int HILO_W = 2
) (
  input logic       clk,
  input logic       reset,
  div_iter_if.slave dif
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [W-1:0]      rem;     // partial remainder; always < divisor once it is nonzero
  logic [W-1:0]      dq;      // dividend shifts out the top, quotient bits shift in below
  logic [W-1:0]      div_b;   // divisor magnitude
  logic              qneg, rneg, b_zero, ovf;
  logic [ROB_W-1:0]  rob_q, rob_out_q;
  logic [HILO_W-1:0] hilo_q, hilo_out_q;
  logic [2*W-1:0]    y_q;

  // Issue-side decode of the raw operands.
  logic         sa_in, sb_in, ovf_in, early_out;
  logic [W-1:0] mag_a_in, mag_b_in;

  always_comb begin
    sa_in    = dif.is_signed & dif.src_A[W-1];
    sb_in    = dif.is_signed & dif.src_B[W-1];
    // -(32'h8000_0000) wraps to itself, which is the correct unsigned magnitude.
    mag_a_in = sa_in ? -dif.src_A : dif.src_A;
    mag_b_in = sb_in ? -dif.src_B : dif.src_B;
    ovf_in   = dif.is_signed && (dif.src_A == {1'b1, {(W-1){1'b0}}}) && (dif.src_B == '1);
`ifdef DIV_EARLY_OUT_EN
    early_out = (dif.src_B == '0) || (dif.src_A == '0) || (mag_a_in < mag_b_in);
`else
    early_out = 1'b0;
`endif
  end

  // One restoring step. The shifted window is W+1 bits wide; when it is >= the
  // divisor the difference is below the divisor, so W bits hold it exactly.
  logic [W:0]   rem_sh;
  logic         ge;
  logic [W-1:0] rem_step, dq_step;

  always_comb begin
    rem_sh   = {rem, dq[W-1]};
    ge       = rem_sh >= {1'b0, div_b};
    rem_step = ge ? (rem_sh[W-1:0] - div_b) : rem_sh[W-1:0];
    dq_step  = {dq[W-2:0], ge};
  end

  // Sign fix-up and special cases. With B=0 the loop leaves |A| in rem (and the
  // early-out path loads it directly), so negating by rneg restores A itself.
  logic [W-1:0] q_fix, r_fix;

  always_comb begin
    q_fix = qneg ? -dq  : dq;
    r_fix = rneg ? -rem : rem;
    if (b_zero) begin
      q_fix = '1;
    end
    if (ovf) begin
      q_fix = {1'b1, {(W-1){1'b0}}};
      r_fix = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dif.go) state_nxt = early_out ? FIX : DIVIDE;
      DIVIDE:  if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      rem        <= '0;
      dq         <= '0;
      div_b      <= '0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
      b_zero     <= 1'b0;
      ovf        <= 1'b0;
      rob_q      <= '0;
      hilo_q     <= '0;
      rob_out_q  <= '0;
      hilo_out_q <= '0;
      y_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.go) begin
            rob_q  <= dif.rob_ptr_in;
            hilo_q <= dif.hilo_prf_ptr_in;
            qneg   <= sa_in ^ sb_in;
            rneg   <= sa_in;
            b_zero <= (dif.src_B == '0);
            ovf    <= ovf_in;
            div_b  <= mag_b_in;
            cnt    <= CW'(W-1);
            if (early_out) begin
              rem <= mag_a_in;
              dq  <= '0;
            end else begin
              rem <= '0;
              dq  <= mag_a_in;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_step;
          dq  <= dq_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          y_q        <= {r_fix, q_fix};
          rob_out_q  <= rob_q;
          hilo_out_q <= hilo_q;
        end
        default: ;
      endcase
    end
  end

  assign dif.ready                = (state == IDLE);
  assign dif.complete             = (state == DONE);
  assign dif.hilo_prf_ptr_val_out = (state == DONE);
  assign dif.y                    = y_q;
  assign dif.rob_ptr_out          = rob_out_q;
  assign dif.hilo_prf_ptr_out     = hilo_out_q;
endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - scoreboard testbench for div_iter (directed corners plus random ops)

module tb_div_iter;
  localparam int W      = 32;
  localparam int ROB_W  = 6;
  localparam int HILO_W = 2;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   completes = 0;

  typedef struct {
    logic [63:0] y;
    logic [5:0]  rob;
    logic [1:0]  hilo;
    int          t;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  div_iter_if #(.W(W), .ROB_W(ROB_W), .HILO_W(HILO_W)) dif ();

  div_iter #(.W(W), .ROB_W(ROB_W), .HILO_W(HILO_W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain arithmetic on 64-bit integers, which truncates toward zero
  // and makes the remainder follow the dividend; -2^31 / -1 yields 2^31 naturally.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    bit early;
    ma = s ? longint'($signed(a)) : longint'({32'd0, a});
    mb = s ? longint'($signed(b)) : longint'({32'd0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    early = (b == 32'd0) || (a == 32'd0) || (ma < mb);
    return (EARLY_EN && early) ? 2 : 34;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] rob, input logic [1:0] hilo, input bit track,
                       output int t);
    int waited;
    waited = 0;
    @(negedge clk);
    while (dif.ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (dif.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", dif.ready);
    end
    dif.go              = 1'b1;
    dif.is_signed       = s;
    dif.src_A           = a;
    dif.src_B           = b;
    dif.rob_ptr_in      = rob;
    dif.hilo_prf_ptr_in = hilo;
    t = cyc;
    if (track) begin
      sb.push_back('{y: ref_div(s, a, b), rob: rob, hilo: hilo, t: t, lat: ref_lat(s, a, b)});
      pushes++;
    end
    @(negedge clk);
    dif.go = 1'b0;
    check("ready_low_T1", 64'(dif.ready), 64'd0);
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dif.complete === 1'b1) begin
      completes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_complete: got complete=1 at cycle %0d expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("y",        dif.y, mon_e.y);
        check("rob",      64'(dif.rob_ptr_out), 64'(mon_e.rob));
        check("hilo",     64'(dif.hilo_prf_ptr_out), 64'(mon_e.hilo));
        check("val_out",  64'(dif.hilo_prf_ptr_val_out), 64'd1);
        check("ready_in_done", 64'(dif.ready), 64'd0);
        check("latency",  64'(cyc - mon_e.t), 64'(mon_e.lat));
      end
    end
  end

  initial begin
    int t, t2, sel;
    logic s;
    logic [31:0] a, b;

    dif.go = 1'b0;
    dif.is_signed = 1'b0;
    dif.src_A = '0;
    dif.src_B = '0;
    dif.rob_ptr_in = '0;
    dif.hilo_prf_ptr_in = '0;

    repeat (3) @(negedge clk);
    check("rst_ready",    64'(dif.ready), 64'd1);
    check("rst_complete", 64'(dif.complete), 64'd0);
    check("rst_val_out",  64'(dif.hilo_prf_ptr_val_out), 64'd0);
    check("rst_y",        dif.y, 64'd0);
    check("rst_rob",      64'(dif.rob_ptr_out), 64'd0);
    check("rst_hilo",     64'(dif.hilo_prf_ptr_out), 64'd0);
    reset = 1'b0;

    // DIVU 100/7 with ready watched over the whole busy window.
    issue(1'b0, 32'd100, 32'd7, 6'd5, 2'd2, 1'b1, t);
    for (int k = 2; k <= 34; k++) begin
      @(negedge clk);
      check("ready_busy", 64'(dif.ready), 64'd0);
    end
    @(negedge clk);
    check("ready_T35", 64'(dif.ready), 64'd1);

    issue(1'b1, 32'hFFFF_FF9C, 32'd7,         6'd1,  2'd1, 1'b1, t);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd2,  2'd0, 1'b1, t);
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 6'd3,  2'd3, 1'b1, t);
    issue(1'b1, 32'd123,       32'd0,         6'd4,  2'd1, 1'b1, t);
    issue(1'b0, 32'd123,       32'd0,         6'd6,  2'd2, 1'b1, t);
    issue(1'b1, 32'd0,         32'hFFFF_FFF9, 6'd7,  2'd3, 1'b1, t);
    issue(1'b1, 32'hFFFF_FFFD, 32'd10,        6'd8,  2'd0, 1'b1, t);
    issue(1'b1, 32'd100,       32'hFFFF_FFF9, 6'd10, 2'd1, 1'b1, t);

    // A go while busy must be ignored; the next accepted go lands at T+35.
    issue(1'b0, 32'd1000, 32'd3, 6'd11, 2'd2, 1'b1, t);
    repeat (4) @(negedge clk);
    dif.go = 1'b1;
    dif.is_signed = 1'b0;
    dif.src_A = 32'd50;
    dif.src_B = 32'd5;
    dif.rob_ptr_in = 6'd63;
    dif.hilo_prf_ptr_in = 2'd3;
    @(negedge clk);
    dif.go = 1'b0;
    issue(1'b0, 32'd77, 32'd8, 6'd12, 2'd0, 1'b1, t2);
    check("reissue_T35", 64'(t2 - t), 64'd35);

    // Reset mid-divide: the aborted op must never complete.
    issue(1'b0, 32'd12345678, 32'd77, 6'd13, 2'd1, 1'b0, t);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready",    64'(dif.ready), 64'd1);
    check("abort_complete", 64'(dif.complete), 64'd0);
    issue(1'b1, 32'hFFFF_0000, 32'd9, 6'd14, 2'd2, 1'b1, t);

    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = 32'h8000_0000;
        1: b = 32'd0;
        2: b = 32'hFFFF_FFFF;
        3: a = $urandom_range(0, 15);
        4: b = $urandom_range(1, 20);
        5: a = 32'd0;
        default: ;
      endcase
      issue(s, a, b, 6'($urandom), 2'($urandom), 1'b1, t);
    end

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    repeat (40) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("complete_count",     64'(completes), 64'(pushes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
